// File: rtl/mod_updown_counter_pkg.sv
// Shared constants for the up/down counter: direction encoding on ctrl and
// the limit-handling mode selected by SATURATE.
package mod_updown_counter_pkg;

  localparam logic UP   = 1'b1;
  localparam logic DOWN = 1'b0;

  localparam logic WRAP = 1'b0;
  localparam logic SAT  = 1'b1;

endpackage

// File: rtl/mod_updown_next.sv
// Combinational step logic: next count and roll condition for one enabled step.
// A step past a limit wraps or holds, depending on SATURATE.
module mod_updown_next
  import mod_updown_counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 16,
  parameter int SATURATE = 0
) (
  input  logic [WIDTH-1:0] q_i,
  input  logic             ctrl_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] next_o,
  output logic             roll_o
);

  localparam logic [WIDTH-1:0] MAX_C    = WIDTH'(MODULUS - 1);
  localparam logic             SAT_MODE = (SATURATE != 0) ? SAT : WRAP;

  // Limits are compared explicitly so a non-power-of-two MODULUS wraps correctly.
  always_comb begin
    next_o = q_i;
    roll_o = 1'b0;
    if (en_i) begin
      if (ctrl_i == UP) begin
        if (q_i == MAX_C) begin
          roll_o = 1'b1;
          if (SAT_MODE == WRAP) next_o = '0;
        end else begin
          next_o = q_i + WIDTH'(1);
        end
      end else begin
        if (q_i == '0) begin
          roll_o = 1'b1;
          if (SAT_MODE == WRAP) next_o = MAX_C;
        end else begin
          next_o = q_i - WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: rtl/mod_updown_counter.sv
// Modulo up/down counter with parallel load, registered roll pulse and a
// combinational terminal-count flag for the current direction.
module mod_updown_counter
  import mod_updown_counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 16,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             ctrl,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             roll
);

  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             roll_q, roll_d;
  logic [WIDTH-1:0] step_next;
  logic             step_roll;
  logic [WIDTH-1:0] din_clamped;

  mod_updown_next #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS),
    .SATURATE(SATURATE)
  ) u_next (
    .q_i   (count_q),
    .ctrl_i(ctrl),
    .en_i  (en),
    .next_o(step_next),
    .roll_o(step_roll)
  );

  // din > MAX_C is the same test as din >= MODULUS without needing WIDTH+1 bits.
  assign din_clamped = (din > MAX_C) ? MAX_C : din;

  always_comb begin
    count_d = step_next;
    roll_d  = step_roll;
    if (load) begin
      count_d = din_clamped;
      roll_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      roll_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      roll_q  <= roll_d;
    end
  end

  assign q    = count_q;
  assign roll = roll_q;
  assign tc   = ((ctrl == UP) && (count_q == MAX_C)) || ((ctrl == DOWN) && (count_q == '0));

endmodule

// File: tb/tb_mod_updown_counter.sv
// Bench for mod_updown_counter: a wrap and a saturating MODULUS=10 instance
// sharing stimulus, plus an 8-bit MODULUS=256 wrap instance.
module tb_mod_updown_counter;

  logic       clk = 1'b0;
  logic       rst, en, ctrl, load;
  logic [3:0] din;
  logic [3:0] a_q, b_q;
  logic       a_tc, a_roll, b_tc, b_roll;

  logic       c_rst, c_en, c_ctrl, c_load;
  logic [7:0] c_din, c_q;
  logic       c_tc, c_roll;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  mod_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) dut_a (
    .clk(clk), .rst(rst), .en(en), .ctrl(ctrl), .load(load), .din(din),
    .q(a_q), .tc(a_tc), .roll(a_roll)
  );

  mod_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) dut_b (
    .clk(clk), .rst(rst), .en(en), .ctrl(ctrl), .load(load), .din(din),
    .q(b_q), .tc(b_tc), .roll(b_roll)
  );

  mod_updown_counter #(.WIDTH(8), .MODULUS(256), .SATURATE(0)) dut_c (
    .clk(clk), .rst(c_rst), .en(c_en), .ctrl(c_ctrl), .load(c_load), .din(c_din),
    .q(c_q), .tc(c_tc), .roll(c_roll)
  );

  typedef struct {
    logic       rst, load, en, ctrl;
    logic [3:0] din;
    logic [3:0] q;
    logic       roll, tc;
  } vec_t;

  typedef struct {
    int         id;
    logic [7:0] q;
    logic       roll, tc;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", name, act, req);
  endtask

  task automatic set_in(input logic r, input logic ld, input logic e, input logic c, input logic [3:0] d);
    rst = r; load = ld; en = e; ctrl = c; din = d;
  endtask

  task automatic set_c(input logic r, input logic ld, input logic e, input logic c, input logic [7:0] d);
    c_rst = r; c_load = ld; c_en = e; c_ctrl = c; c_din = d;
  endtask

  task automatic push_exp(input int id, input logic [7:0] q_e, input logic roll_e, input logic tc_e);
    exp_t e;
    e.id = id; e.q = q_e; e.roll = roll_e; e.tc = tc_e;
    sb.push_back(e);
  endtask

  // One clock, then compare every expectation queued for this edge.
  task automatic tick(input string tag);
    exp_t e;
    logic [7:0] aq;
    logic       ar, at;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.id)
        0:       begin aq = {4'b0, a_q}; ar = a_roll; at = a_tc; end
        1:       begin aq = {4'b0, b_q}; ar = b_roll; at = b_tc; end
        default: begin aq = c_q;         ar = c_roll; at = c_tc; end
      endcase
      chk({tag, "/q"},    aq,          e.q);
      chk({tag, "/roll"}, {7'b0, ar},  {7'b0, e.roll});
      chk({tag, "/tc"},   {7'b0, at},  {7'b0, e.tc});
    end
  endtask

  task automatic add(input logic r, input logic ld, input logic e, input logic c, input logic [3:0] d,
                     input logic [3:0] q_e, input logic roll_e, input logic tc_e);
    vec_t v;
    v.rst = r; v.load = ld; v.en = e; v.ctrl = c; v.din = d;
    v.q = q_e; v.roll = roll_e; v.tc = tc_e;
    vecs.push_back(v);
  endtask

  initial begin
    set_in(1'b1, 1'b0, 1'b0, 1'b1, 4'd0);
    set_c (1'b1, 1'b0, 1'b0, 1'b1, 8'd0);

    // Wrap instance, MODULUS=10: rst load en ctrl din | q roll tc
    add(1, 0, 0, 1, 0,   0, 0, 0);
    add(1, 0, 0, 0, 0,   0, 0, 1);
    for (int i = 1; i <= 9; i++) add(0, 0, 1, 1, 0, 4'(i), 0, (i == 9));
    add(0, 0, 1, 1, 0,   0, 1, 0);
    add(0, 0, 1, 1, 0,   1, 0, 0);
    add(0, 0, 1, 1, 0,   2, 0, 0);
    add(0, 0, 1, 0, 0,   1, 0, 0);
    add(0, 0, 1, 0, 0,   0, 0, 1);
    add(0, 0, 1, 0, 0,   9, 1, 0);
    add(0, 0, 1, 0, 0,   8, 0, 0);
    add(0, 0, 0, 0, 0,   8, 0, 0);
    add(0, 1, 0, 1, 13,  9, 0, 1);
    add(0, 1, 1, 1, 4,   4, 0, 0);
    add(0, 1, 0, 1, 9,   9, 0, 1);
    add(0, 0, 1, 1, 0,   0, 1, 0);
    add(0, 1, 1, 1, 9,   9, 0, 1);
    add(1, 0, 1, 1, 0,   0, 0, 0);
    add(0, 0, 1, 1, 0,   1, 0, 0);
    add(0, 0, 0, 0, 0,   1, 0, 0);
    add(1, 1, 1, 1, 5,   0, 0, 0);
    add(0, 0, 1, 1, 0,   1, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      set_in(vecs[i].rst, vecs[i].load, vecs[i].en, vecs[i].ctrl, vecs[i].din);
      push_exp(0, {4'b0, vecs[i].q}, vecs[i].roll, vecs[i].tc);
      tick($sformatf("vec%0d", i));
    end

    // Saturating instance: climb from 7 and sit at the top limit.
    set_in(1, 0, 0, 1, 0); push_exp(1, 0, 0, 0); tick("sat_rst");
    set_in(0, 1, 0, 1, 7); push_exp(1, 7, 0, 0); tick("sat_ld7");
    set_in(0, 0, 1, 1, 0);
    push_exp(1, 8, 0, 0); tick("sat_up1");
    push_exp(1, 9, 0, 1); tick("sat_up2");
    push_exp(1, 9, 1, 1); tick("sat_up3");
    push_exp(1, 9, 1, 1); tick("sat_up4");
    push_exp(1, 9, 1, 1); tick("sat_up5");
    set_in(0, 1, 1, 1, 9); push_exp(1, 9, 0, 1); tick("sat_ld_lim");
    set_in(0, 1, 0, 0, 0); push_exp(1, 0, 0, 1); tick("sat_ld0");
    set_in(0, 0, 1, 0, 0); push_exp(1, 0, 1, 1); tick("sat_dn_blk");
    set_in(0, 0, 1, 1, 0); push_exp(1, 1, 0, 0); tick("sat_dir_chg");
    set_in(0, 0, 0, 1, 0);

    // 8-bit full-range wrap.
    set_c(1, 0, 0, 1, 0);   push_exp(2, 0, 0, 0);   tick("w8_rst");
    set_c(0, 1, 0, 1, 254); push_exp(2, 254, 0, 0); tick("w8_ld");
    set_c(0, 0, 1, 1, 0);
    push_exp(2, 255, 0, 1); tick("w8_up1");
    push_exp(2, 0, 1, 0);   tick("w8_up2");
    push_exp(2, 1, 0, 0);   tick("w8_up3");
    set_c(0, 0, 1, 0, 0);
    push_exp(2, 0, 0, 1);   tick("w8_dn1");
    push_exp(2, 255, 1, 0); tick("w8_dn2");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mod_updown_counter.md
MOD_UPDOWN_COUNTER -- requirements
Module: mod_updown_counter

Interface
REQ-001 Parameter WIDTH, default 4: counter width in bits (legal range 2..32).
REQ-002 Parameter MODULUS, default 16: count range is 0..MODULUS-1 (legal range 2..2**WIDTH).
REQ-003 Parameter SATURATE, default 0: 0 = wrap at limits, 1 = hold at limits.
REQ-004 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-005 Port rst, input, 1: synchronous, active-high reset.
REQ-006 Port en, input, 1: count enable; 1 = step this cycle.
REQ-007 Port ctrl, input, 1: direction; 1 = up, 0 = down.
REQ-008 Port load, input, 1: synchronous parallel load strobe.
REQ-009 Port din, input, WIDTH: parallel load value.
REQ-010 Port q, output, WIDTH: registered count value.
REQ-011 Port tc, output, 1: combinational terminal count for the current direction.
REQ-012 Port roll, output, 1: registered one-cycle event pulse for a wrap or a blocked step.

Function
REQ-013 Update priority SHALL be rst > load > en; with none of these active, q holds.
REQ-014 With load=1, q SHALL take din on the next edge, regardless of en and ctrl.
REQ-015 A din value >= MODULUS SHALL be clamped: q takes MODULUS-1.
REQ-016 With en=1, ctrl=1 and q < MODULUS-1, q SHALL become q+1 on the next edge.
REQ-017 With en=1, ctrl=0 and q > 0, q SHALL become q-1 on the next edge.
REQ-018 Up step at q=MODULUS-1, SATURATE=0: q SHALL become 0.
REQ-019 Down step at q=0, SATURATE=0: q SHALL become MODULUS-1.
REQ-020 Up step at q=MODULUS-1, or down step at q=0, with SATURATE=1: q SHALL hold.
REQ-021 roll SHALL be 1 for exactly the cycle after an edge on which REQ-018, REQ-019 or REQ-020 applied; otherwise roll SHALL be 0.
REQ-022 roll SHALL be 0 after any load edge, including a load of a limit value.
REQ-023 tc SHALL equal (ctrl & q==MODULUS-1) | (~ctrl & q==0), independent of en.
REQ-024 A direction change SHALL take effect on the same edge; no idle cycle is inserted.
REQ-025 All next-state arithmetic SHALL be WIDTH bits with explicit limit compare; no reliance on natural 2**WIDTH overflow, so that non-power-of-two MODULUS is supported.
REQ-026 Latency from en/ctrl/load to q and roll SHALL be one clock; the only combinational output is tc.

Reset
REQ-027 On an rst=1 edge, q SHALL be 0 and roll SHALL be 0; this overrides load and en.
REQ-028 Reset asserted mid-count SHALL take effect on the next edge; no pending roll SHALL survive it.
REQ-029 After reset, tc SHALL be 1 when ctrl=0 and 0 when ctrl=1 (q=0, MODULUS>1).
REQ-030 There SHALL be no asynchronous reset path.

Structure
REQ-031 A shared package SHALL hold the direction constants (UP=1, DOWN=0) and the mode constants (WRAP=0, SAT=1).
REQ-032 Sub-module mod_updown_next SHALL compute the next count and the roll condition combinationally from q, ctrl, en and the parameters.
REQ-033 mod_updown_counter SHALL contain only the q/roll registers, the priority mux, the load clamp and the tc decode.

Verification (WIDTH=4, MODULUS=10 unless stated)
REQ-034 Reset, then en=1, ctrl=1 for 12 clocks -> q runs 1..9, 0, 1, 2; roll=1 only in the cycle q=0; tc=1 while q=9.
REQ-035 From q=2, en=1, ctrl=0 for 4 clocks -> q runs 1, 0, 9, 8; roll=1 in the cycle q=9; tc=1 while q=0.
REQ-036 SATURATE=1, count up from 7 for 5 clocks -> q runs 8, 9, 9, 9, 9; roll=1 in each cycle after a blocked step.
REQ-037 load=1, din=13 -> q=9 on the next edge. Then load=1 and en=1 together, din=4 -> q=4 and roll=0.
REQ-038 rst=1 asserted while q=9 with en=1, ctrl=1 -> q=0 and roll=0 on the next edge; counting resumes from 0 after rst is released.
REQ-039 WIDTH=8, MODULUS=256, wrap mode, up from 254 -> q runs 255, 0; roll=1 once.
